// File: rtl/ps2_key_event_ctrl_if.sv
// ps2_key_event_ctrl_if
//  Key-event stream between ps2_key_event_ctrl (master) and a key consumer (slave).
//  ev_data   {ext, brk, code[7:0]} of the FIFO head
//  ev_valid  an event is available
//  ev_ready  consumer accepts the head when ev_valid && ev_ready
interface ps2_key_event_ctrl_if;
    logic [9:0] ev_data;
    logic       ev_valid;
    logic       ev_ready;

    modport master (output ev_data, output ev_valid, input ev_ready);
    modport slave  (input ev_data, input ev_valid, output ev_ready);
endinterface

// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl
//  Turns the PS/2 receiver's code register into a clean key-event stream.
//  A new code_vector value must hold for SETTLE_CYCLES samples before it is
//  committed and classified (make/break, normal/extended); resulting events are
//  queued in a FIFO with a valid/ready handshake. Receiver error episodes and
//  FIFO drops are counted for status.
// Ports
//  CLOCK        system clock, rising edge
//  rst_n        asynchronous active-low reset
//  code_vector  receiver code register {prefix_byte, code_byte}
//  ERR_CODE     receiver status: bit0 parity error, bit1 framing error
//  ev           event stream (master side of ps2_key_event_ctrl_if)
//  fifo_level   entries held, 0..FIFO_DEPTH
//  overflow     sticky: an event was dropped on a full FIFO
//  err_count    saturating count of error episodes
//  stat_clr     synchronous clear of overflow and err_count
//
// state    | meaning
// WAIT     | idle, watching for code_vector to differ from the last committed value
// SETTLE   | candidate value seen, counting consecutive equal samples
// DECODE   | one cycle: classify the committed value, push at most one event
module ps2_key_event_ctrl #(
    parameter int FIFO_DEPTH    = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int ERRCNT_W      = 8
) (
    input  logic                          CLOCK,
    input  logic                          rst_n,
    input  logic [15:0]                   code_vector,
    input  logic [1:0]                    ERR_CODE,
    ps2_key_event_ctrl_if.master          ev,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [ERRCNT_W-1:0]           err_count,
    input  logic                          stat_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    localparam logic [1:0] ST_WAIT   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_DECODE = 2'd2;

    logic [1:0]    state;
    logic [15:0]   cv_last;
    logic [15:0]   cand;
    logic [CW-1:0] cnt;
    logic          pend_ext;

    logic          push_req;
    logic [9:0]    push_data;
    logic          pend_ext_nxt;

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic          full;
    logic          pop;
    logic          push;
    logic          err_prev;

    // Settle / commit sequencer
    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_WAIT;
            cv_last <= '0;
            cand    <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (code_vector != cv_last) begin
                        cand  <= code_vector;
                        cnt   <= CW'(1);
                        state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == CW'(SETTLE_CYCLES)) begin
                        cv_last <= cand;
                        state   <= ST_DECODE;
                    end else if (code_vector == cv_last) begin
                        // transient glitch that fell back to the committed value
                        state <= ST_WAIT;
                    end else if (code_vector == cand) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cand <= code_vector;
                        cnt  <= CW'(1);
                    end
                end
                ST_DECODE: state <= ST_WAIT;
                default:   state <= ST_WAIT;
            endcase
        end
    end

    // Classification of the committed value; first matching rule wins
    always_comb begin
        push_req     = 1'b0;
        push_data    = '0;
        pend_ext_nxt = pend_ext;
        if (state == ST_DECODE) begin
            if (cv_last == 16'h0000) begin
                pend_ext_nxt = 1'b0;
            end else if (cv_last == 16'hE0F0) begin
                pend_ext_nxt = 1'b1;
            end else if (cv_last[7:0] == 8'hE0 || cv_last[7:0] == 8'hF0) begin
                pend_ext_nxt = pend_ext;
            end else if (cv_last[15:8] == 8'h00) begin
                push_req  = 1'b1;
                push_data = {2'b00, cv_last[7:0]};
            end else if (cv_last[15:8] == 8'hE0) begin
                push_req  = 1'b1;
                push_data = {2'b10, cv_last[7:0]};
            end else if (cv_last[15:8] == 8'hF0) begin
                push_req     = 1'b1;
                push_data    = {pend_ext, 1'b1, cv_last[7:0]};
                pend_ext_nxt = 1'b0;
            end else begin
                pend_ext_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) pend_ext <= 1'b0;
        else        pend_ext <= pend_ext_nxt;
    end

    // Event FIFO; a push on a full FIFO still succeeds when the head pops in the same cycle
    assign full = (level == (AW+1)'(FIFO_DEPTH));
    assign pop  = (level != '0) && ev.ev_ready;
    assign push = push_req && (!full || pop);

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign ev.ev_data  = mem[rd_ptr];
    assign ev.ev_valid = (level != '0);
    assign fifo_level  = level;

    // Status: stat_clr takes priority over a same-cycle set or increment
    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            err_count <= '0;
            err_prev  <= 1'b0;
        end else begin
            err_prev <= (ERR_CODE != 2'b00);
            if (stat_clr) begin
                overflow  <= 1'b0;
                err_count <= '0;
            end else begin
                if (push_req && full && !pop) overflow <= 1'b1;
                if ((ERR_CODE != 2'b00) && !err_prev && (err_count != '1))
                    err_count <= err_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
module tb_ps2_key_event_ctrl;
    logic        CLOCK = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] code_vector;
    logic [1:0]  ERR_CODE;
    logic        stat_clr;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic [7:0]  err_count;

    ps2_key_event_ctrl_if evi();

    ps2_key_event_ctrl #(.FIFO_DEPTH(8), .SETTLE_CYCLES(4), .ERRCNT_W(8)) dut (
        .CLOCK       (CLOCK),
        .rst_n       (rst_n),
        .code_vector (code_vector),
        .ERR_CODE    (ERR_CODE),
        .ev          (evi),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .err_count   (err_count),
        .stat_clr    (stat_clr)
    );

    always #5 CLOCK = ~CLOCK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] cv;
        int          hold;
        int          exp_n;
        logic [9:0]  exp_data;
    } vec_t;

    vec_t tbl [11];

    // Hold a value for 'hold' cycles with ev_ready=1, counting events seen
    task automatic hold_count(input logic [15:0] cv, input int hold,
                              output int n, output logic [9:0] data);
        code_vector = cv;
        n = 0;
        data = '0;
        repeat (hold) begin
            @(negedge CLOCK);
            if (evi.ev_valid && evi.ev_ready) begin
                n++;
                data = evi.ev_data;
            end
        end
    endtask

    // ---------------- reference model (random phase) ----------------
    logic [15:0] m_last;
    bit          m_pend;
    logic [9:0]  exp_q [$];
    int          m_err;
    bit          drv_err_prev;

    task automatic model_decode(input logic [15:0] v);
        logic [7:0] hi, lo;
        hi = v[15:8];
        lo = v[7:0];
        if (v == 16'h0000)                 m_pend = 0;
        else if (v == 16'hE0F0)            m_pend = 1;
        else if (lo == 8'hE0 || lo == 8'hF0) begin end
        else if (hi == 8'h00)              exp_q.push_back({2'b00, lo});
        else if (hi == 8'hE0)              exp_q.push_back({2'b10, lo});
        else if (hi == 8'hF0) begin
            exp_q.push_back({m_pend, 1'b1, lo});
            m_pend = 0;
        end else                           m_pend = 0;
    endtask

    function automatic logic [15:0] gen_value();
        logic [7:0]  code;
        logic [31:0] r;
        code = 8'($urandom_range(1, 127));
        r = $urandom;
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hE0F0;
            3:       return {8'hE0, code};
            4:       return {8'hF0, code};
            5:       return {(r[0] ? 8'hE0 : 8'h00), 8'hF0};
            6:       return r[15:0];
            default: return {8'h00, code};
        endcase
    endfunction

    // One random-phase cycle: we are at a negedge; drive, predict pop, advance
    task automatic tick(input bit randomize_in);
        logic [1:0] e;
        if (randomize_in) begin
            e = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            evi.ev_ready = ($urandom_range(0, 3) != 0);
        end else begin
            e = 2'b00;
            evi.ev_ready = 1'b1;
        end
        ERR_CODE = e;
        if (e != 2'b00 && !drv_err_prev && m_err < 255) m_err++;
        drv_err_prev = (e != 2'b00);
        if (evi.ev_valid && evi.ev_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rand_unexpected: got 0x%0h, expected no event", evi.ev_data);
            end else begin
                check("rand_event", int'(evi.ev_data), int'(exp_q.pop_front()));
            end
        end
        @(negedge CLOCK);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int          n;
        logic [9:0]  d;
        logic [15:0] val, prev_seg;
        int          len;
        bit          long_seg;

        tbl[0]  = '{16'hE0F0, 10, 0, 10'h000};
        tbl[1]  = '{16'hF075, 10, 1, 10'h375};
        tbl[2]  = '{16'hE06B, 10, 1, 10'h26B};
        tbl[3]  = '{16'hF06B, 10, 1, 10'h16B};
        tbl[4]  = '{16'h001C, 10, 1, 10'h01C};
        tbl[5]  = '{16'h0000,  2, 0, 10'h000};
        tbl[6]  = '{16'h001C, 10, 0, 10'h000};
        tbl[7]  = '{16'h00F0, 10, 0, 10'h000};
        tbl[8]  = '{16'hF01C, 10, 1, 10'h11C};
        tbl[9]  = '{16'h0000, 10, 0, 10'h000};
        tbl[10] = '{16'h1234, 10, 0, 10'h000};

        code_vector  = 16'h0000;
        ERR_CODE     = 2'b00;
        stat_clr     = 1'b0;
        evi.ev_ready = 1'b1;
        rst_n        = 1'b0;
        repeat (3) @(negedge CLOCK);
        check("rst_valid", int'(evi.ev_valid), 0);
        check("rst_data", int'(evi.ev_data), 0);
        check("rst_level", int'(fifo_level), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_err_count", int'(err_count), 0);
        rst_n = 1'b1;
        @(negedge CLOCK);

        // Latency: first sample at edge N, event visible after edge N+5 for one cycle
        code_vector = 16'h001C;
        @(posedge CLOCK);
        repeat (4) @(posedge CLOCK);
        @(negedge CLOCK);
        check("lat_valid_n4", int'(evi.ev_valid), 0);
        @(negedge CLOCK);
        check("lat_valid_n5", int'(evi.ev_valid), 1);
        check("lat_data", int'(evi.ev_data), 'h01C);
        @(negedge CLOCK);
        check("lat_valid_n6", int'(evi.ev_valid), 0);
        repeat (4) @(negedge CLOCK);

        // Table-driven decode sequences
        for (int i = 0; i < 11; i++) begin
            hold_count(tbl[i].cv, tbl[i].hold, n, d);
            check($sformatf("tbl%0d_count", i), n, tbl[i].exp_n);
            if (tbl[i].exp_n > 0)
                check($sformatf("tbl%0d_data", i), int'(d), int'(tbl[i].exp_data));
        end

        // FIFO fill and overflow
        evi.ev_ready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            code_vector = {8'h00, 8'(k)};
            repeat (8) @(negedge CLOCK);
        end
        check("ovf_level", int'(fifo_level), 8);
        check("ovf_flag", int'(overflow), 1);
        evi.ev_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("ovf_drain%0d", k), int'(evi.ev_data), k);
            @(negedge CLOCK);
        end
        check("ovf_drained_level", int'(fifo_level), 0);
        stat_clr = 1'b1;
        @(negedge CLOCK);
        stat_clr = 1'b0;
        check("ovf_cleared", int'(overflow), 0);

        // Full FIFO with push and pop in the same cycle
        evi.ev_ready = 1'b0;
        for (int k = 'h11; k <= 'h18; k++) begin
            code_vector = {8'h00, 8'(k)};
            repeat (8) @(negedge CLOCK);
        end
        check("pp_full_level", int'(fifo_level), 8);
        code_vector = 16'h0019;
        @(posedge CLOCK);
        repeat (4) @(posedge CLOCK);
        @(negedge CLOCK);
        evi.ev_ready = 1'b1;
        @(negedge CLOCK);
        evi.ev_ready = 1'b0;
        check("pp_level", int'(fifo_level), 8);
        check("pp_overflow", int'(overflow), 0);
        evi.ev_ready = 1'b1;
        for (int k = 'h12; k <= 'h19; k++) begin
            check($sformatf("pp_drain%0h", k), int'(evi.ev_data), k);
            @(negedge CLOCK);
        end

        // Error episodes and stat_clr priority
        ERR_CODE = 2'b01; @(negedge CLOCK);
        ERR_CODE = 2'b00; @(negedge CLOCK);
        ERR_CODE = 2'b10; @(negedge CLOCK);
        ERR_CODE = 2'b00; @(negedge CLOCK);
        ERR_CODE = 2'b01; @(negedge CLOCK);
        ERR_CODE = 2'b00; @(negedge CLOCK);
        check("err_count3", int'(err_count), 3);
        ERR_CODE = 2'b01;
        stat_clr = 1'b1;
        @(negedge CLOCK);
        ERR_CODE = 2'b00;
        stat_clr = 1'b0;
        @(negedge CLOCK);
        check("err_clr_wins", int'(err_count), 0);

        // Reset mid-operation drops queued events
        evi.ev_ready = 1'b0;
        code_vector = 16'h0021; repeat (8) @(negedge CLOCK);
        code_vector = 16'h0022; repeat (8) @(negedge CLOCK);
        check("mid_level_before", int'(fifo_level), 2);
        rst_n = 1'b0;
        code_vector = 16'h0000;
        #1;
        check("mid_rst_level", int'(fifo_level), 0);
        check("mid_rst_valid", int'(evi.ev_valid), 0);
        @(negedge CLOCK);
        rst_n = 1'b1;
        @(negedge CLOCK);

        // Randomized segments against the reference model
        m_last = 16'h0000;
        m_pend = 0;
        m_err = 0;
        drv_err_prev = 0;
        prev_seg = 16'h0000;
        for (int s = 0; s < 200; s++) begin
            do val = gen_value(); while (val == prev_seg);
            long_seg = ($urandom_range(0, 9) < 7);
            len = long_seg ? $urandom_range(6, 12) : $urandom_range(1, 3);
            if (long_seg && val != m_last) begin
                m_last = val;
                model_decode(val);
            end
            code_vector = val;
            prev_seg = val;
            for (int c = 0; c < len; c++) tick(1'b1);
        end
        for (int c = 0; c < 30; c++) tick(1'b0);
        check("rand_leftover", exp_q.size(), 0);
        check("rand_level", int'(fifo_level), 0);
        check("rand_overflow", int'(overflow), 0);
        check("rand_err_count", int'(err_count), m_err);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
